seven_segment_capture: RTL and testbench

Receive-side counterpart of the hex-to-segment decoder. It monitors a multiplexed, active-low common-anode display bus (anodes plus {dp,g,f,e,d,c,b,a}) and recovers the displayed hex value and decimal points. It debounces scan transitions, decodes each digit's glyph back to a nibble, and assembles a full frame once every digit has been seen. It is used as a display sniffer and self-check block in lab designs and benches.

---
 rtl/seven_segment_capture.sv | 135 +++++++++++++
 tb/tb_seven_segment_capture.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: recovers hex digits and decimal points from a multiplexed active-low display bus.
// Define SEVEN_SEG_SYNC_EN to add a two-flop input synchronizer (2 cycles extra latency).
module seven_segment_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [7:0]              segments,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   dp,
  output logic                    value_valid,
  output logic                    frame_valid,
  output logic                    pattern_error
);
  localparam int W  = NUM_DIGITS + 8;
  localparam int CW = $clog2(STABLE_CYCLES);
  logic [W-1:0] smp, last_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, value_q, value_d;
  logic [NUM_DIGITS-1:0] sdp_q, sdp_d, dp_q, dp_d, seen_q, seen_d, sel;
  logic vv_q, vv_d, fv_q, fv_d, pe_q, pe_d, eq, accept, one_hot, hit;
  logic [3:0] nib;
`ifdef SEVEN_SEG_SYNC_EN
  logic [W-1:0] sync1_q, sync2_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= {an, segments};
      sync2_q <= sync1_q;
    end
  assign smp = sync2_q;
`else
  assign smp = {an, segments};
`endif
  function automatic logic [4:0] decode(input logic [6:0] g);
    case (g)
      7'b1000000: decode = 5'h10;
      7'b1111001: decode = 5'h11;
      7'b0100100: decode = 5'h12;
      7'b0110000: decode = 5'h13;
      7'b0011001: decode = 5'h14;
      7'b0010010: decode = 5'h15;
      7'b0000010: decode = 5'h16;
      7'b1111000: decode = 5'h17;
      7'b0000000: decode = 5'h18;
      7'b0010000: decode = 5'h19;
      7'b0001000: decode = 5'h1A;
      7'b0000011: decode = 5'h1B;
      7'b1000110: decode = 5'h1C;
      7'b0100001: decode = 5'h1D;
      7'b0000110: decode = 5'h1E;
      7'b0001110: decode = 5'h1F;
      default:    decode = 5'h00;
    endcase
  endfunction
  // cnt_q counts repeats after the first sample, so acceptance lands on the STABLE_CYCLES-th edge
  always_comb begin
    eq       = smp == last_q;
    cnt_d    = !eq ? '0 : (cnt_q == CW'(STABLE_CYCLES - 1) ? cnt_q : cnt_q + CW'(1));
    accept   = eq && cnt_q == CW'(STABLE_CYCLES - 2);
    sel      = ~smp[W-1:8];
    one_hot  = sel != '0 && (sel & (sel - NUM_DIGITS'(1))) == '0;
    {hit, nib} = decode(smp[6:0]);
    shadow_d = shadow_q;
    sdp_d    = sdp_q;
    seen_d   = seen_q;
    value_d  = value_q;
    dp_d     = dp_q;
    vv_d     = vv_q;
    fv_d     = 1'b0;
    pe_d     = 1'b0;
    if (accept && one_hot) begin
      if (hit) begin
        for (int i = 0; i < NUM_DIGITS; i++)
          if (sel[i]) begin
            shadow_d[4*i+:4] = nib;
            sdp_d[i]         = ~smp[7];
          end
        seen_d = seen_q | sel;
        if (&seen_d) begin
          value_d = shadow_d;
          dp_d    = sdp_d;
          fv_d    = 1'b1;
          vv_d    = 1'b1;
          seen_d  = '0;
        end
      end else pe_d = 1'b1;
    end
    if (clear) begin
      shadow_d = '0;
      sdp_d    = '0;
      seen_d   = '0;
      value_d  = '0;
      dp_d     = '0;
      vv_d     = 1'b0;
      fv_d     = 1'b0;
      pe_d     = 1'b0;
      cnt_d    = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last_q   <= '1;
      cnt_q    <= '0;
      shadow_q <= '0;
      sdp_q    <= '0;
      seen_q   <= '0;
      value_q  <= '0;
      dp_q     <= '0;
      vv_q     <= 1'b0;
      fv_q     <= 1'b0;
      pe_q     <= 1'b0;
    end else begin
      last_q   <= smp;
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      seen_q   <= seen_d;
      value_q  <= value_d;
      dp_q     <= dp_d;
      vv_q     <= vv_d;
      fv_q     <= fv_d;
      pe_q     <= pe_d;
    end
  assign value         = value_q;
  assign dp            = dp_q;
  assign value_valid   = vv_q;
  assign frame_valid   = fv_q;
  assign pattern_error = pe_q;
endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture: directed scans of a 4-digit display bus with hand-computed expectations.
module tb_seven_segment_capture;
  logic clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
  logic [3:0] an = 4'b1111;
  logic [7:0] segments = 8'hFF;
  logic [15:0] value;
  logic [3:0] dp;
  logic value_valid, frame_valid, pattern_error;
  int n_cmp = 0, n_bad = 0, fv_cnt = 0, pe_cnt = 0, fv_base, pe_base;
  seven_segment_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .segments(segments), .clear(clear),
    .value(value), .dp(dp), .value_valid(value_valid),
    .frame_valid(frame_valid), .pattern_error(pattern_error)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (frame_valid) fv_cnt++;
    if (pattern_error) pe_cnt++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
    an = a;
    segments = s;
    repeat (n) @(negedge clk);
  endtask
  task automatic scan(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
    drive(4'b1110, s0, 8);
    drive(4'b1101, s1, 8);
    drive(4'b1011, s2, 8);
    drive(4'b0111, s3, 8);
    drive(4'b1111, 8'hFF, 4);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("reset_value", 32'(value), 32'h0);
    check("reset_flags", {dp, value_valid, frame_valid, pattern_error}, 7'h0);
    rst_n = 1'b1;
    @(negedge clk);
    // scan 4321 and pin down the frame pulse timing
    fv_base = fv_cnt;
    drive(4'b1110, 8'hF9, 8);
    drive(4'b1101, 8'hA4, 8);
    drive(4'b1011, 8'hB0, 8);
    drive(4'b0111, 8'h99, 3);
    check("fv_before_accept", 32'(frame_valid), 32'h0);
    check("value_before_frame", 32'(value_valid), 32'h0);
    drive(4'b0111, 8'h99, 1);
    check("fv_pulse", 32'(frame_valid), 32'h1);
    check("value_4321_at_pulse", 32'(value), 32'h4321);
    drive(4'b0111, 8'h99, 1);
    check("fv_one_cycle", 32'(frame_valid), 32'h0);
    drive(4'b0111, 8'h99, 6);
    drive(4'b1111, 8'hFF, 4);
    check("scan_value", 32'(value), 32'h4321);
    check("scan_dp", 32'(dp), 32'h0);
    check("scan_vv", 32'(value_valid), 32'h1);
    check("scan_fv_count", 32'(fv_cnt - fv_base), 32'h1);
    // glitch on digit 0 must not mark it seen
    fv_base = fv_cnt;
    drive(4'b1110, 8'hC0, 3);
    drive(4'b1111, 8'hFF, 5);
    drive(4'b1101, 8'hA4, 8);
    drive(4'b1011, 8'hB0, 8);
    drive(4'b0111, 8'h99, 8);
    drive(4'b1111, 8'hFF, 4);
    check("glitch_no_frame", 32'(fv_cnt - fv_base), 32'h0);
    check("glitch_value_held", 32'(value), 32'h4321);
    drive(4'b1110, 8'hC0, 8);
    drive(4'b1111, 8'hFF, 4);
    check("glitch_then_d0_frame", 32'(fv_cnt - fv_base), 32'h1);
    check("glitch_then_d0_value", 32'(value), 32'h4320);
    // illegal glyph on digit 1
    fv_base = fv_cnt;
    pe_base = pe_cnt;
    drive(4'b1110, 8'hF9, 8);
    drive(4'b1101, 8'hBF, 5);
    drive(4'b1101, 8'hBF, 3);
    drive(4'b1011, 8'hB0, 8);
    drive(4'b0111, 8'h99, 8);
    drive(4'b1111, 8'hFF, 4);
    check("illegal_pe_once", 32'(pe_cnt - pe_base), 32'h1);
    check("illegal_no_frame", 32'(fv_cnt - fv_base), 32'h0);
    drive(4'b1101, 8'hA4, 8);
    drive(4'b1111, 8'hFF, 4);
    check("rescan_frame", 32'(fv_cnt - fv_base), 32'h1);
    check("rescan_value", 32'(value), 32'h4321);
    // decimal point on digit 2 showing 6
    scan(8'hF9, 8'hA4, 8'h02, 8'h99);
    check("dp_value", 32'(value), 32'h4621);
    check("dp_bits", 32'(dp), 32'h4);
    // multi-anode and blank are ignored
    fv_base = fv_cnt;
    pe_base = pe_cnt;
    drive(4'b1100, 8'hF9, 10);
    drive(4'b1111, 8'hFF, 10);
    drive(4'b1100, 8'hBF, 10);
    drive(4'b1111, 8'hFF, 10);
    check("multi_no_pe", 32'(pe_cnt - pe_base), 32'h0);
    check("multi_state", {dp, value}, {4'h4, 16'h4621});
    drive(4'b1011, 8'hB0, 8);
    drive(4'b0111, 8'h99, 8);
    drive(4'b1111, 8'hFF, 4);
    check("multi_seen_clean", 32'(fv_cnt - fv_base), 32'h0);
    drive(4'b1110, 8'hF9, 8);
    drive(4'b1101, 8'hA4, 8);
    drive(4'b1111, 8'hFF, 4);
    check("multi_then_frame", 32'(fv_cnt - fv_base), 32'h1);
    check("multi_then_value", {dp, value}, {4'h0, 16'h4321});
    // clear on the completing edge
    fv_base = fv_cnt;
    drive(4'b1110, 8'hF9, 8);
    drive(4'b1101, 8'hA4, 8);
    drive(4'b1011, 8'hB0, 8);
    drive(4'b0111, 8'h99, 3);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("clear_no_fv", 32'(frame_valid), 32'h0);
    check("clear_value", 32'(value), 32'h0);
    check("clear_flags", {dp, value_valid}, 5'h0);
    drive(4'b0111, 8'h99, 6);
    drive(4'b1111, 8'hFF, 4);
    check("clear_fv_count", 32'(fv_cnt - fv_base), 32'h0);
    check("clear_vv_stays", 32'(value_valid), 32'h0);
    // asynchronous reset mid-scan discards the partial frame
    scan(8'hF9, 8'hA4, 8'h02, 8'h99);
    check("pre_reset_value", {dp, value, value_valid}, {4'h4, 16'h4621, 1'b1});
    drive(4'b1110, 8'hF9, 8);
    drive(4'b1101, 8'hA4, 5);
    #2 rst_n = 1'b0;
    #1 check("async_reset_value", 32'(value), 32'h0);
    check("async_reset_flags", {dp, value_valid, frame_valid, pattern_error}, 7'h0);
    @(negedge clk);
    rst_n = 1'b1;
    fv_base = fv_cnt;
    drive(4'b1111, 8'hFF, 4);
    drive(4'b1011, 8'hB0, 8);
    drive(4'b0111, 8'h99, 8);
    drive(4'b1111, 8'hFF, 4);
    check("reset_partial_dropped", 32'(fv_cnt - fv_base), 32'h0);
    drive(4'b1110, 8'hF9, 8);
    drive(4'b1101, 8'hA4, 8);
    drive(4'b1111, 8'hFF, 4);
    check("reset_recapture_fv", 32'(fv_cnt - fv_base), 32'h1);
    check("reset_recapture_value", {dp, value, value_valid}, {4'h0, 16'h4321, 1'b1});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
